alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-side initiator for the 8-bit combinational
// arithmetic unit. Commands arrive over a valid/ready handshake. Each one is
// driven onto the unit for WAIT_CYC enabled edges, and the 17-bit result is
// then returned through a small response FIFO. A divide-by-zero is trapped
// here and never reaches the unit.
// Optional build macro: ALU_OPSEQ_STATS_EN adds the saturating stat_ops and
// stat_errs counters and their output ports.
module alu_op_sequencer #(
  parameter int WAIT_CYC = 1,
  parameter int DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [1:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [1:0]  alu_s,
  output logic        alu_en_n,
  input  logic [16:0] alu_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [16:0] rsp_data,
  output logic [1:0]  rsp_op,
  output logic        rsp_err
`ifdef ALU_OPSEQ_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [7:0]  stat_errs
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 20;  // {err, op[1:0], data[16:0]}

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  localparam logic [1:0] OP_DIV = 2'b00;

  // Control and unit-drive state
  logic [0:0]       state_reg, state_next;
  logic [3:0]       wait_cnt_reg, wait_cnt_next;
  logic [7:0]       alu_a_reg, alu_a_next;
  logic [7:0]       alu_b_reg, alu_b_next;
  logic [1:0]       alu_s_reg, alu_s_next;
  logic             alu_en_n_reg, alu_en_n_next;

  // Response FIFO state
  logic [ENT_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [ENT_W-1:0] head_reg, head_next;

  logic             accept;
  logic             trap;
  logic             issue;
  logic             done;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] push_entry;

  // cmd_ready depends only on registered state, never on rsp_ready. Because
  // accept requires a free slot and only one operation is ever in flight,
  // the DRIVE result always finds room in the FIFO.
  assign cmd_ready = (state_reg == ST_IDLE) && (count_reg < CNT_W'(DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign trap      = accept && (cmd_op == OP_DIV) && (cmd_b == 8'd0);
  assign issue     = accept && !trap;
  assign done      = (state_reg == ST_DRIVE) && (wait_cnt_reg == 4'd0);

  // Trap and DRIVE completion are mutually exclusive: they occur in different states.
  assign push       = trap || done;
  assign pop        = rsp_valid && rsp_ready;
  assign push_entry = trap ? {1'b1, OP_DIV, 17'd0} : {1'b0, alu_s_reg, alu_y};

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_s     = alu_s_reg;
  assign alu_en_n  = alu_en_n_reg;

  assign rsp_valid = (count_reg != '0);
  assign rsp_err   = head_reg[19];
  assign rsp_op    = head_reg[18:17];
  assign rsp_data  = head_reg[16:0];

  // Next-state logic for the command FSM and the unit drive registers
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    alu_a_next    = alu_a_reg;
    alu_b_next    = alu_b_reg;
    alu_s_next    = alu_s_reg;
    alu_en_n_next = alu_en_n_reg;
    case (state_reg)
      ST_IDLE: begin
        if (issue) begin
          alu_a_next    = cmd_a;
          alu_b_next    = cmd_b;
          alu_s_next    = cmd_op;
          alu_en_n_next = 1'b0;
          wait_cnt_next = 4'(WAIT_CYC - 1);
          state_next    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (wait_cnt_reg != 4'd0) begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end else begin
          alu_en_n_next = 1'b1;
          state_next    = ST_IDLE;
        end
      end
      default: begin
        alu_en_n_next = 1'b1;
        state_next    = ST_IDLE;
      end
    endcase
  end

  // FSM and unit drive registers. An asynchronous reset drops any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= 4'd0;
      alu_a_reg    <= 8'd0;
      alu_b_reg    <= 8'd0;
      alu_s_reg    <= 2'd0;
      alu_en_n_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      alu_a_reg    <= alu_a_next;
      alu_b_reg    <= alu_b_next;
      alu_s_reg    <= alu_s_next;
      alu_en_n_reg <= alu_en_n_next;
    end
  end

  assign rd_ptr_inc = rd_ptr_reg + 1'b1;

  // FIFO pointer, occupancy and registered head-entry computation
  always_comb begin
    rd_ptr_next = pop  ? rd_ptr_inc : rd_ptr_reg;
    wr_ptr_next = push ? (wr_ptr_reg + 1'b1) : wr_ptr_reg;
    count_next  = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
    head_next = head_reg;
    if (count_next == '0) begin
      head_next = '0;
    end else if ((count_reg == '0) || (pop && (count_reg == CNT_W'(1)))) begin
      // The new head is the entry being pushed on this edge.
      head_next = push_entry;
    end else if (pop) begin
      head_next = mem_reg[rd_ptr_inc];
    end
  end

  // FIFO storage. It is written only and needs no reset: only occupied slots are read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_entry;
    end
  end

  // FIFO control registers. Reset flushes the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

`ifdef ALU_OPSEQ_STATS_EN
  logic [15:0] stat_ops_reg;
  logic [7:0]  stat_errs_reg;

  assign stat_ops  = stat_ops_reg;
  assign stat_errs = stat_errs_reg;

  // Saturating counters: every FIFO push, and trapped divide-by-zero pushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_reg  <= 16'd0;
      stat_errs_reg <= 8'd0;
    end else begin
      if (push && (stat_ops_reg != 16'hFFFF)) begin
        stat_ops_reg <= stat_ops_reg + 16'd1;
      end
      if (trap && (stat_errs_reg != 8'hFF)) begin
        stat_errs_reg <= stat_errs_reg + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer. There are two instances: u_dut1
// (WAIT_CYC=1) and u_dut3 (WAIT_CYC=3). Each instance drives a behavioural
// model of the external arithmetic unit.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n;

  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [1:0]  cmd_op;
  logic [7:0]  alu_a, alu_b;
  logic [1:0]  alu_s;
  logic        alu_en_n;
  logic [16:0] alu_y;
  logic        rsp_valid, rsp_ready;
  logic [16:0] rsp_data;
  logic [1:0]  rsp_op;
  logic        rsp_err;

  logic        cmd_valid_3, cmd_ready_3;
  logic [7:0]  cmd_a_3, cmd_b_3;
  logic [1:0]  cmd_op_3;
  logic [7:0]  alu_a_3, alu_b_3;
  logic [1:0]  alu_s_3;
  logic        alu_en_n_3;
  logic [16:0] alu_y_3;
  logic        rsp_valid_3, rsp_ready_3;
  logic [16:0] rsp_data_3;
  logic [1:0]  rsp_op_3;
  logic        rsp_err_3;

`ifdef ALU_OPSEQ_STATS_EN
  logic [15:0] stat_ops, stat_ops_3;
  logic [7:0]  stat_errs, stat_errs_3;
`endif

  int tests_run;
  int tests_failed;

  alu_op_sequencer #(.WAIT_CYC(1), .DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_en_n(alu_en_n),
    .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err)
`ifdef ALU_OPSEQ_STATS_EN
    , .stat_ops(stat_ops), .stat_errs(stat_errs)
`endif
  );

  alu_op_sequencer #(.WAIT_CYC(3), .DEPTH(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3),
    .cmd_a(cmd_a_3), .cmd_b(cmd_b_3), .cmd_op(cmd_op_3),
    .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_s(alu_s_3), .alu_en_n(alu_en_n_3),
    .alu_y(alu_y_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3),
    .rsp_data(rsp_data_3), .rsp_op(rsp_op_3), .rsp_err(rsp_err_3)
`ifdef ALU_OPSEQ_STATS_EN
    , .stat_ops(stat_ops_3), .stat_errs(stat_errs_3)
`endif
  );

  // Behavioural arithmetic unit: 00 div (0 when a <= b), 01 add, 10 sub, 11 mul
  function automatic logic [16:0] unit_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] s, input logic en_n);
    logic [16:0] ea, eb;
    ea = {9'd0, a};
    eb = {9'd0, b};
    if (en_n) return 17'd0;
    case (s)
      2'b00:   return (a > b) ? ea / eb : 17'd0;
      2'b01:   return ea + eb;
      2'b10:   return ea - eb;
      default: return ea * eb;
    endcase
  endfunction

  assign alu_y   = unit_model(alu_a, alu_b, alu_s, alu_en_n);
  assign alu_y_3 = unit_model(alu_a_3, alu_b_3, alu_s_3, alu_en_n_3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bounded wait for cmd_ready on the selected instance, sampled on negedges
  task automatic wait_ready(input int which);
    logic rdy;
    rdy = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      rdy = (which == 3) ? cmd_ready_3 : cmd_ready;
      if (rdy) break;
    end
    check("cmd_ready_wait", {31'd0, rdy}, 32'd1);
  endtask

  // One command through u_dut1 with rsp_ready held high
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [16:0] exp, input logic exp_err);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    wait_ready(1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (exp_err) begin
      check({tag, "_en_n"},  {31'd0, alu_en_n}, 32'd1);
    end else begin
      check({tag, "_en_n"},  {31'd0, alu_en_n}, 32'd0);
      check({tag, "_alu_a"}, {24'd0, alu_a}, {24'd0, a});
      check({tag, "_alu_b"}, {24'd0, alu_b}, {24'd0, b});
      check({tag, "_alu_s"}, {30'd0, alu_s}, {30'd0, op});
      check({tag, "_early"}, {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
      check({tag, "_en_off"}, {31'd0, alu_en_n}, 32'd1);
    end
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_data"},  {15'd0, rsp_data}, {15'd0, exp});
    check({tag, "_op"},    {30'd0, rsp_op}, {30'd0, op});
    check({tag, "_err"},   {31'd0, rsp_err}, {31'd0, exp_err});
    $display("[TB] %s a=%0d b=%0d op=%0d data=%05h err=%0d", tag, a, b, op, rsp_data, rsp_err);
    @(posedge clk); #1;
    check({tag, "_popped"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_en_idle"}, {31'd0, alu_en_n}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] bp_exp [5];
    logic        acc;
    logic        got5;

    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    cmd_valid    = 1'b0; cmd_a   = '0; cmd_b   = '0; cmd_op   = '0; rsp_ready   = 1'b1;
    cmd_valid_3  = 1'b0; cmd_a_3 = '0; cmd_b_3 = '0; cmd_op_3 = '0; rsp_ready_3 = 1'b1;

    // Reset state
    #12;
    check("rst_en_n",  {31'd0, alu_en_n}, 32'd1);
    check("rst_alu_a", {24'd0, alu_a}, 32'd0);
    check("rst_alu_b", {24'd0, alu_b}, 32'd0);
    check("rst_alu_s", {30'd0, alu_s}, 32'd0);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_data",  {15'd0, rsp_data}, 32'd0);
    check("rst_op",    {30'd0, rsp_op}, 32'd0);
    check("rst_err",   {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Basic operations, WAIT_CYC=1
    run_op("add",  8'd200, 8'd100, 2'b01, 17'h0012C, 1'b0);
    run_op("mul",  8'd255, 8'd255, 2'b11, 17'h0FE01, 1'b0);
    run_op("sub",  8'd5,   8'd10,  2'b10, 17'h1FFFB, 1'b0);
    run_op("div0", 8'd9,   8'd0,   2'b00, 17'h00000, 1'b1);
`ifdef ALU_OPSEQ_STATS_EN
    check("stat_ops",  {16'd0, stat_ops}, 32'd4);
    check("stat_errs", {24'd0, stat_errs}, 32'd1);
`endif
    run_op("div",  8'd9,   8'd3,   2'b00, 17'h00003, 1'b0);

    // Backpressure: four results fill the FIFO, the fifth command waits
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) bp_exp[i] = 17'(10 * (i + 1) + i);
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_a     = 8'(10 * (i + 1));
      cmd_b     = 8'(i);
      cmd_op    = 2'b01;
      wait_ready(1);
      @(posedge clk); #1;
    end
    cmd_a = 8'd50;
    cmd_b = 8'd4;
    repeat (3) @(negedge clk);
    check("bp_full_ready", {31'd0, cmd_ready}, 32'd0);
    check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_hold_data",  {15'd0, rsp_data}, {15'd0, bp_exp[0]});
    @(posedge clk); #1;
    check("bp_hold_data2", {15'd0, rsp_data}, {15'd0, bp_exp[0]});
    rsp_ready = 1'b1;
    got5 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_drain%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("bp_drain%0d_data", k), {15'd0, rsp_data}, {15'd0, bp_exp[k]});
      $display("[TB] drain %0d data=%05h", k, rsp_data);
      acc = cmd_valid && cmd_ready;
      @(posedge clk); #1;
      if (acc) begin
        cmd_valid = 1'b0;
        got5      = 1'b1;
      end
    end
    check("bp_fifth_accepted", {31'd0, got5}, 32'd1);
    @(negedge clk);
    check("bp_empty", {31'd0, rsp_valid}, 32'd0);

    // WAIT_CYC=3 latency on u_dut3
    cmd_valid_3 = 1'b1; cmd_a_3 = 8'd7; cmd_b_3 = 8'd8; cmd_op_3 = 2'b01;
    wait_ready(3);
    @(posedge clk); #1;
    cmd_valid_3 = 1'b0;
    check("w3_en0", {31'd0, alu_en_n_3}, 32'd0);
    @(posedge clk); #1;
    check("w3_en1",    {31'd0, alu_en_n_3}, 32'd0);
    check("w3_valid1", {31'd0, rsp_valid_3}, 32'd0);
    @(posedge clk); #1;
    check("w3_en2",    {31'd0, alu_en_n_3}, 32'd0);
    check("w3_valid2", {31'd0, rsp_valid_3}, 32'd0);
    @(posedge clk); #1;
    check("w3_en3",    {31'd0, alu_en_n_3}, 32'd1);
    check("w3_valid3", {31'd0, rsp_valid_3}, 32'd1);
    check("w3_data",   {15'd0, rsp_data_3}, 32'd15);
    $display("[TB] w3 add a=7 b=8 data=%05h", rsp_data_3);
    @(posedge clk); #1;

    // Reset pulsed in the middle of DRIVE
    cmd_valid_3 = 1'b1; cmd_a_3 = 8'd1; cmd_b_3 = 8'd2; cmd_op_3 = 2'b01;
    wait_ready(3);
    @(posedge clk); #1;
    cmd_valid_3 = 1'b0;
    @(posedge clk); #1;
    check("mid_en_before", {31'd0, alu_en_n_3}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_en_n",  {31'd0, alu_en_n_3}, 32'd1);
    check("mid_rst_valid", {31'd0, rsp_valid_3}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, cmd_ready_3}, 32'd1);
    check("post_rst_en_n",  {31'd0, alu_en_n_3}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("no_stale%0d", k), {31'd0, rsp_valid_3}, 32'd0);
    end
    $display("[TB] reset mid-drive dropped in-flight command");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
